// File: rtl/ks_pipelined_subtractor.sv
// ks_pipelined_subtractor: three-stage Kogge-Stone a - b - bin with compare flags and valid/ready flow control
module ks_pipelined_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             lt_u,
  output logic             lt_s
);
  localparam int L   = $clog2(WIDTH);
  localparam int S2L = (L < 3) ? L : 3;

  function automatic logic [WIDTH-1:0] prefix_g(input logic [WIDTH-1:0] gin, pin, input int lo, hi);
    logic [WIDTH-1:0] g, p, gn, pn;
    g = gin;
    p = pin;
    for (int k = lo; k < hi; k++) begin
      gn = g;
      pn = p;
      for (int i = 1 << k; i < WIDTH; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << k)]);
        pn[i] = p[i] & p[i - (1 << k)];
      end
      g = gn;
      p = pn;
    end
    return g;
  endfunction

  function automatic logic [WIDTH-1:0] prefix_p(input logic [WIDTH-1:0] pin, input int lo, hi);
    logic [WIDTH-1:0] p, pn;
    p = pin;
    for (int k = lo; k < hi; k++) begin
      pn = p;
      for (int i = 1 << k; i < WIDTH; i++)
        pn[i] = p[i] & p[i - (1 << k)];
      p = pn;
    end
    return p;
  endfunction

  logic             stall, adv;
  logic             v1_q, v2_q, v3_q;
  logic [WIDTH-1:0] g1_d, p1_d, g1_q, p1_q;
  logic             ci1_d, ci1_q, am1_q, bm1_q;
  logic [WIDTH-1:0] g2_d, pp2_d, g2_q, pp2_q, p2_q;
  logic             ci2_q, am2_q, bm2_q;
  logic [WIDTH-1:0] gcar, diff_d, diff_q;
  logic             bout_d, ovf_d, zero_d, lt_s_d;
  logic             bout_q, ovf_q, zero_q, lt_s_q;

  assign stall    = v3_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Stage 1 inputs: subtraction as a + ~b with carry-in ~bin
  always_comb begin
    g1_d  = a & ~b;
    p1_d  = a ^ ~b;
    ci1_d = ~bin;
  end

  // Stage 2 inputs: fold carry-in into bit 0, then the first prefix levels
  always_comb begin
    g2_d  = prefix_g({g1_q[WIDTH-1:1], g1_q[0] | (p1_q[0] & ci1_q)}, {p1_q[WIDTH-1:1], 1'b0}, 0, S2L);
    pp2_d = prefix_p({p1_q[WIDTH-1:1], 1'b0}, 0, S2L);
  end

  // Stage 3 inputs: remaining prefix levels, sum bits and flags
  always_comb begin
    gcar   = prefix_g(g2_q, pp2_q, S2L, L);
    diff_d = p2_q ^ {gcar[WIDTH-2:0], ci2_q};
    bout_d = ~gcar[WIDTH-1];
    ovf_d  = (am2_q ^ bm2_q) & (am2_q ^ diff_d[WIDTH-1]);
    zero_d = ~|diff_d;
    lt_s_d = diff_d[WIDTH-1] ^ ovf_d;
  end

  // Stage 1 register: captures operands whenever the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      g1_q  <= '0;
      p1_q  <= '0;
      ci1_q <= 1'b0;
      am1_q <= 1'b0;
      bm1_q <= 1'b0;
    end else if (adv) begin
      v1_q  <= in_valid;
      g1_q  <= g1_d;
      p1_q  <= p1_d;
      ci1_q <= ci1_d;
      am1_q <= a[WIDTH-1];
      bm1_q <= b[WIDTH-1];
    end
  end

  // Stage 2 register: partial group generate/propagate plus the raw propagate for the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      g2_q  <= '0;
      pp2_q <= '0;
      p2_q  <= '0;
      ci2_q <= 1'b0;
      am2_q <= 1'b0;
      bm2_q <= 1'b0;
    end else if (adv) begin
      v2_q  <= v1_q;
      g2_q  <= g2_d;
      pp2_q <= pp2_d;
      p2_q  <= p1_q;
      ci2_q <= ci1_q;
      am2_q <= am1_q;
      bm2_q <= bm1_q;
    end
  end

  // Stage 3 register: result and flags, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      lt_s_q <= 1'b0;
    end else if (adv) begin
      v3_q   <= v2_q;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      lt_s_q <= lt_s_d;
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign lt_u      = bout_q;
  assign lt_s      = lt_s_q;
endmodule

// File: tb/tb_ks_pipelined_subtractor.sv
// tb_ks_pipelined_subtractor: directed and streaming checks of the pipelined subtractor
module tb_ks_pipelined_subtractor;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout, ovf, zero, lt_u, lt_s;
  logic [36:0]  obs;
  logic [36:0]  q[$];
  int           total = 0;
  int           bad = 0;
  int           n_out = 0;

  ks_pipelined_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero), .lt_u(lt_u), .lt_s(lt_s)
  );

  always #5 clk = ~clk;
  assign obs = {diff, bout, ovf, zero, lt_u, lt_s};

  function automatic logic [36:0] model(input logic [W-1:0] x, y, input logic bi);
    logic [W:0] r;
    logic       v;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    v = (x[W-1] ^ y[W-1]) & (x[W-1] ^ r[W-1]);
    return {r[W-1:0], r[W], v, r[W-1:0] == '0, r[W], r[W-1] ^ v};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) check("spurious_out", 1, 0);
        else check("stream_res", obs, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
    end
  end

  task automatic send(input logic [W-1:0] av, bv, input logic bi);
    int   n;
    logic ok;
    n = 0;
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] av, bv, input logic bi, input logic [36:0] exp);
    send(av, bv, bi);
    @(posedge clk); #1;
    check({tag, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check(tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [36:0] snap;
    logic [11:0] iv, ovs;
    int          base;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outs", obs, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("sub_5_3",    32'd5,        32'd3,        1'b0, {32'd2,        5'b00000});
    run_one("underflow",  32'd0,        32'd1,        1'b0, {32'hFFFFFFFF, 5'b10011});
    run_one("borrow_in",  32'd7,        32'd7,        1'b1, {32'hFFFFFFFF, 5'b10011});
    run_one("equal",      32'd7,        32'd7,        1'b0, {32'd0,        5'b00100});
    run_one("ovf_neg",    32'h80000000, 32'd1,        1'b0, {32'h7FFFFFFF, 5'b01001});
    run_one("ovf_pos",    32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, {32'h80000000, 5'b11010});
    @(posedge clk); #1;

    base = n_out;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      if (i >= 3) check("stream_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_count", n_out - base, 100);

    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 32'h100 + k; b = k; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    a = 32'hDEADBEEF; b = 32'h12345678; bin = 1'b1;
    check("bp_full_valid", out_valid, 1);
    check("bp_head", obs, {32'h100, 5'b00000});
    snap = obs;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_frozen", obs, snap);
    end
    out_ready = 1'b1;
    iv = 12'h025;
    ovs = '0;
    for (int c = 0; c < 12; c++) begin
      in_valid = iv[c];
      if (c > 0 && iv[c]) begin a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      ovs[c] = out_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_gap_pattern", ovs, 12'h12F);
    check("bp_drained", q.size(), 0);

    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outs", obs, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 0);
    end
    run_one("after_rst", 32'h12345678, 32'h00000678, 1'b0, {32'h12345000, 5'b00000});
    @(posedge clk); #1;
    check("final_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
